// File: rtl/axil_reg_bank_pkg.sv
// Shared types for the AXI4-Lite register bank: response codes, FSM states
// and the byte-address to word-index helper.
// Latency: n/a (declarations only). Backpressure: n/a.
package axil_reg_bank_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_GOT_AW,
    W_GOT_W,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Drops the byte-offset bits so the remaining address counts whole words.
  function automatic int unsigned word_idx(input logic [31:0] addr, input int unsigned lsb);
    return addr >> lsb;
  endfunction

endpackage

// File: rtl/axil_reg_cell.sv
// One register of the bank: byte-strobe merge of bus writes, hardware update
// taking priority over everything, optional clear. Latency: 1 cycle to o_q.
// Backpressure: none, every request is applied on the clock edge it is seen.
// Ports: i_clk/i_rst_n; i_bus_we/i_bus_wdata/i_bus_wstrb bus write;
//        i_hw_we/i_hw_wdata hardware write; i_clr clear; o_q register value.
module axil_reg_cell
  import axil_reg_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_bus_we,
  input  logic [DATA_WIDTH-1:0]   i_bus_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_bus_wstrb,
  input  logic                    i_hw_we,
  input  logic [DATA_WIDTH-1:0]   i_hw_wdata,
  input  logic                    i_clr,
  output logic [DATA_WIDTH-1:0]   o_q
);

  logic [DATA_WIDTH-1:0] r_q;
  logic [DATA_WIDTH-1:0] w_merged;

  always_comb begin
    w_merged = r_q;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (i_bus_wstrb[b]) w_merged[b*8 +: 8] = i_bus_wdata[b*8 +: 8];
    end
  end

  // Hardware value wins outright; a bus write beats a clear-on-read so that
  // freshly written data is never lost to a concurrent read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_q <= '0;
    else if (i_hw_we)  r_q <= i_hw_wdata;
    else if (i_bus_we) r_q <= w_merged;
    else if (i_clr)    r_q <= '0;
  end

  assign o_q = r_q;

endmodule

// File: rtl/axil_reg_bank.sv
// Parametrised AXI4-Lite slave register bank with RO registers, error
// responses, hardware update ports and per-register write pulses.
// Latency: write response 1 cycle after commit, read data 1 cycle after AR;
// backpressure: one outstanding write and one outstanding read, readies drop
// while a response waits for bready/rready.
// Ports: ACLK/ARESETN; s_axi_* AXI4-Lite slave; reg_q flattened registers;
//        hw_we/hw_wdata hardware update; wr_pulse per-register write strobe.
// Optional: define AXIL_REG_BANK_COR_EN to make COR_MASK registers
// clear-on-read.
module axil_reg_bank
  import axil_reg_bank_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          NUM_REGS   = 16,
  parameter int unsigned          ADDR_WIDTH = 8,
  parameter logic [NUM_REGS-1:0]  RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0]  COR_MASK   = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS-1:0]            hw_we,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wdata,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);

`ifdef AXIL_REG_BANK_COR_EN
  localparam logic [NUM_REGS-1:0] COR_ACT = COR_MASK;
`else
  // Feature compiled out: no register clears on read.
  localparam logic [NUM_REGS-1:0] COR_ACT = COR_MASK & '0;
`endif

  // Holds the readies low while reset is asserted and for the first edge after.
  logic r_live;

  wr_state_t r_wstate, w_wstate_nxt;
  rd_state_t r_rstate, w_rstate_nxt;

  logic [ADDR_WIDTH-1:0]          r_awaddr;
  logic [DATA_WIDTH-1:0]          r_wdata;
  logic [STRB_W-1:0]              r_wstrb;
  resp_t                          r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0]          r_rdata;
  logic [NUM_REGS-1:0]            r_wr_pulse;

  logic                           w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [ADDR_WIDTH-1:0]          w_cmt_addr;
  logic [DATA_WIDTH-1:0]          w_cmt_data;
  logic [STRB_W-1:0]              w_cmt_strb;
  int unsigned                    w_widx, w_ridx;
  logic                           w_ro_hit, w_wr_hit, w_rd_hit;
  resp_t                          w_cmt_resp;
  logic [DATA_WIDTH-1:0]          w_rd_word;
  logic [NUM_REGS-1:0]            w_bus_we, w_clr;
  logic [NUM_REGS*DATA_WIDTH-1:0] w_reg_q;

  assign s_axi_awready = r_live && (r_wstate == W_IDLE || r_wstate == W_GOT_W);
  assign s_axi_wready  = r_live && (r_wstate == W_IDLE || r_wstate == W_GOT_AW);
  assign s_axi_bvalid  = (r_wstate == W_RESP);
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_live && (r_rstate == R_IDLE);
  assign s_axi_rvalid  = (r_rstate == R_DATA);
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign wr_pulse      = r_wr_pulse;
  assign reg_q         = w_reg_q;

  assign w_aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_w_hs  = s_axi_wvalid && s_axi_wready;
  assign w_ar_hs = s_axi_arvalid && s_axi_arready;

  // Write FSM: the commit happens on the edge that accepts the later of AW/W;
  // whichever arrived earlier is taken from its holding register.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_commit     = 1'b0;
    w_cmt_addr   = s_axi_awaddr;
    w_cmt_data   = s_axi_wdata;
    w_cmt_strb   = s_axi_wstrb;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
        end else if (w_aw_hs) begin
          w_wstate_nxt = W_GOT_AW;
        end else if (w_w_hs) begin
          w_wstate_nxt = W_GOT_W;
        end
      end
      W_GOT_AW: begin
        w_cmt_addr = r_awaddr;
        if (w_w_hs) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
        end
      end
      W_GOT_W: begin
        w_cmt_data = r_wdata;
        w_cmt_strb = r_wstrb;
        if (w_aw_hs) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  assign w_widx = word_idx(32'(w_cmt_addr), LSB);
  assign w_ridx = word_idx(32'(s_axi_araddr), LSB);

  always_comb begin
    w_ro_hit  = 1'b0;
    w_wr_hit  = 1'b0;
    w_rd_hit  = 1'b0;
    w_rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (w_widx == i) begin
        w_wr_hit = 1'b1;
        w_ro_hit = RO_MASK[i];
      end
      if (w_ridx == i) begin
        w_rd_hit  = 1'b1;
        w_rd_word = w_reg_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    w_cmt_resp = !w_wr_hit ? RESP_DECERR : (w_ro_hit ? RESP_SLVERR : RESP_OKAY);
  end

  // Read FSM: a single response slot held until rready.
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (s_axi_rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_live     <= 1'b0;
      r_wstate   <= W_IDLE;
      r_rstate   <= R_IDLE;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bresp    <= RESP_OKAY;
      r_rresp    <= RESP_OKAY;
      r_rdata    <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_live     <= 1'b1;
      r_wstate   <= w_wstate_nxt;
      r_rstate   <= w_rstate_nxt;
      r_wr_pulse <= w_bus_we;
      if (w_aw_hs) r_awaddr <= s_axi_awaddr;
      if (w_w_hs) begin
        r_wdata <= s_axi_wdata;
        r_wstrb <= s_axi_wstrb;
      end
      if (w_commit) r_bresp <= w_cmt_resp;
      // Sampled from the flops before this edge's updates: a same-cycle
      // write or clear is not visible in the returned data.
      if (w_ar_hs) begin
        r_rdata <= w_rd_hit ? w_rd_word : '0;
        r_rresp <= w_rd_hit ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_reg
    assign w_bus_we[g] = w_commit && (w_cmt_resp == RESP_OKAY) && (w_widx == g);
    assign w_clr[g]    = w_ar_hs && (w_ridx == g) && COR_ACT[g];

    axil_reg_cell #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_cell (
      .i_clk       (ACLK),
      .i_rst_n     (ARESETN),
      .i_bus_we    (w_bus_we[g]),
      .i_bus_wdata (w_cmt_data),
      .i_bus_wstrb (w_cmt_strb),
      .i_hw_we     (hw_we[g]),
      .i_hw_wdata  (hw_wdata[g*DATA_WIDTH +: DATA_WIDTH]),
      .i_clr       (w_clr[g]),
      .o_q         (w_reg_q[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank built with RO_MASK=0x0002 and
// COR_MASK=0x0001 so the read-only and clear-on-read cases share one
// instance. Inputs change on the falling edge and outputs are sampled there.
module tb_axil_reg_bank;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  logic         ACLK = 1'b0;
  logic         ARESETN;
  logic [7:0]   s_axi_awaddr;
  logic         s_axi_awvalid;
  logic         s_axi_awready;
  logic [31:0]  s_axi_wdata;
  logic [3:0]   s_axi_wstrb;
  logic         s_axi_wvalid;
  logic         s_axi_wready;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_bvalid;
  logic         s_axi_bready;
  logic [7:0]   s_axi_araddr;
  logic         s_axi_arvalid;
  logic         s_axi_arready;
  logic [31:0]  s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rvalid;
  logic         s_axi_rready;
  logic [511:0] reg_q;
  logic [15:0]  hw_we;
  logic [511:0] hw_wdata;
  logic [15:0]  wr_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt [16];

  logic [1:0]  t1_bresp [4] = '{OKAY, SLVERR, OKAY, OKAY};
  logic [31:0] t1_rdata [4] = '{32'h1, 32'h0, 32'h3, 32'h4};

  always #5 ACLK = ~ACLK;

  axil_reg_bank #(
    .DATA_WIDTH(32),
    .NUM_REGS  (16),
    .ADDR_WIDTH(8),
    .RO_MASK   (16'h0002),
    .COR_MASK  (16'h0001)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .reg_q         (reg_q),
    .hw_we         (hw_we),
    .hw_wdata      (hw_wdata),
    .wr_pulse      (wr_pulse)
  );

  always @(negedge ACLK) begin
    if (ARESETN) begin
      for (int i = 0; i < 16; i++) begin
        if (wr_pulse[i]) pulse_cnt[i] = pulse_cnt[i] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int hw_i, input logic [31:0] hw_v, output logic [1:0] resp);
    int   n;
    logic aw_ok, w_ok, aw_acc, w_acc;
    @(negedge ACLK);
    s_axi_awaddr  = a;
    s_axi_awvalid = 1'b1;
    s_axi_wdata   = d;
    s_axi_wstrb   = s;
    s_axi_wvalid  = 1'b1;
    if (hw_i >= 0) begin
      hw_we[hw_i]              = 1'b1;
      hw_wdata[hw_i*32 +: 32]  = hw_v;
    end
    aw_ok = 1'b0;
    w_ok  = 1'b0;
    n     = 0;
    while (!(aw_ok && w_ok) && n < 20) begin
      aw_acc = s_axi_awvalid && s_axi_awready;
      w_acc  = s_axi_wvalid && s_axi_wready;
      @(negedge ACLK);
      hw_we = '0;
      if (aw_acc) begin aw_ok = 1'b1; s_axi_awvalid = 1'b0; end
      if (w_acc)  begin w_ok  = 1'b1; s_axi_wvalid  = 1'b0; end
      n++;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    check("wr_accept", 64'({aw_ok, w_ok}), 64'h3);
    s_axi_bready = 1'b1;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("wr_bvalid", 64'(s_axi_bvalid), 64'h1);
    resp = s_axi_bresp;
    @(negedge ACLK);
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge ACLK);
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("rd_arready", 64'(s_axi_arready), 64'h1);
    @(negedge ACLK);
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("rd_rvalid", 64'(s_axi_rvalid), 64'h1);
    d    = s_axi_rdata;
    resp = s_axi_rresp;
    @(negedge ACLK);
    s_axi_rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]   resp;
    logic [31:0]  rd;
    logic [511:0] snap;

    for (int i = 0; i < 16; i++) pulse_cnt[i] = 0;
    ARESETN       = 1'b0;
    s_axi_awaddr  = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
    hw_we         = '0;
    hw_wdata      = '0;

    // Reset state
    repeat (3) @(negedge ACLK);
    check("rst_awready", 64'(s_axi_awready), 64'h0);
    check("rst_wready",  64'(s_axi_wready),  64'h0);
    check("rst_arready", 64'(s_axi_arready), 64'h0);
    check("rst_bvalid",  64'(s_axi_bvalid),  64'h0);
    check("rst_rvalid",  64'(s_axi_rvalid),  64'h0);
    check("rst_resps",   64'({s_axi_bresp, s_axi_rresp}), 64'h0);
    check("rst_rdata",   64'(s_axi_rdata),   64'h0);
    check("rst_pulse",   64'(wr_pulse),      64'h0);
    check("rst_reg_q",   64'(reg_q != '0),   64'h0);
    ARESETN = 1'b1;
    @(negedge ACLK);

    // Sequential writes 1..4 to words 0..3; word 1 is read-only.
    for (int i = 0; i < 4; i++) begin
      axi_write(8'(i * 4), 32'(i + 1), 4'hF, -1, 32'h0, resp);
      check($sformatf("t1_bresp%0d", i), 64'(resp), 64'(t1_bresp[i]));
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_reg_q%0d", i), 64'(reg_q[i*32 +: 32]), 64'(t1_rdata[i]));
    end
    check("t1_pulse0", 64'(pulse_cnt[0]), 64'd1);
    check("t1_pulse1", 64'(pulse_cnt[1]), 64'd0);
    check("t1_pulse2", 64'(pulse_cnt[2]), 64'd1);
    check("t1_pulse3", 64'(pulse_cnt[3]), 64'd1);
    for (int i = 0; i < 4; i++) begin
      axi_read(8'(i * 4), rd, resp);
      check($sformatf("t1_rdata%0d", i), 64'(rd), 64'(t1_rdata[i]));
      check($sformatf("t1_rresp%0d", i), 64'(resp), 64'(OKAY));
    end

    // Byte strobes: bytes 0 and 2 replaced.
    axi_write(8'h00, 32'hAABBCCDD, 4'hF, -1, 32'h0, resp);
    axi_write(8'h00, 32'h11223344, 4'h5, -1, 32'h0, resp);
    check("t2_bresp", 64'(resp), 64'(OKAY));
    axi_read(8'h00, rd, resp);
    check("t2_rdata", 64'(rd), 64'hAA22CC44);

    // W three cycles ahead of AW, then bready held low for four cycles.
    @(negedge ACLK);
    s_axi_wdata  = 32'h55;
    s_axi_wstrb  = 4'hF;
    s_axi_wvalid = 1'b1;
    check("t3_wready_idle", 64'(s_axi_wready), 64'h1);
    @(negedge ACLK);
    s_axi_wvalid = 1'b0;
    repeat (2) @(negedge ACLK);
    check("t3_awready_gotw", 64'(s_axi_awready), 64'h1);
    check("t3_wready_gotw",  64'(s_axi_wready),  64'h0);
    check("t3_no_bvalid",    64'(s_axi_bvalid),  64'h0);
    s_axi_awaddr  = 8'h08;
    s_axi_awvalid = 1'b1;
    @(negedge ACLK);
    s_axi_awvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t3_bvalid_hold", 64'(s_axi_bvalid),  64'h1);
      check("t3_bresp",       64'(s_axi_bresp),   64'(OKAY));
      check("t3_no_awready",  64'(s_axi_awready), 64'h0);
      @(negedge ACLK);
    end
    check("t3_reg2",   64'(reg_q[64 +: 32]), 64'h55);
    check("t3_pulse2", 64'(pulse_cnt[2]),    64'd2);
    s_axi_bready = 1'b1;
    @(negedge ACLK);
    s_axi_bready = 1'b0;
    check("t3_bvalid_done", 64'(s_axi_bvalid),  64'h0);
    check("t3_awready_back", 64'(s_axi_awready), 64'h1);

    // Out-of-range word index 16.
    snap = reg_q;
    axi_write(8'h40, 32'hDEADBEEF, 4'hF, -1, 32'h0, resp);
    check("t4_bresp", 64'(resp), 64'(DECERR));
    check("t4_reg_q_same", 64'(reg_q == snap), 64'h1);
    axi_read(8'h40, rd, resp);
    check("t4_rdata", 64'(rd),   64'h0);
    check("t4_rresp", 64'(resp), 64'(DECERR));

    // Read-only word 1, then hardware update colliding with bus writes.
    axi_write(8'h04, 32'hFFFF, 4'hF, -1, 32'h0, resp);
    check("t5_ro_bresp", 64'(resp), 64'(SLVERR));
    check("t5_ro_value", 64'(reg_q[32 +: 32]), 64'h0);
    axi_write(8'h04, 32'hFFFF, 4'hF, 1, 32'h1234, resp);
    check("t5_ro_hw_bresp", 64'(resp), 64'(SLVERR));
    axi_read(8'h04, rd, resp);
    check("t5_ro_hw_rdata", 64'(rd),   64'h1234);
    check("t5_ro_rresp",    64'(resp), 64'(OKAY));
    check("t5_pulse1",      64'(pulse_cnt[1]), 64'd0);
    axi_write(8'h0C, 32'h99, 4'hF, 3, 32'h77, resp);
    check("t5_rw_hw_bresp", 64'(resp), 64'(OKAY));
    check("t5_pulse3",      64'(pulse_cnt[3]), 64'd2);
    axi_read(8'h0C, rd, resp);
    check("t5_rw_hw_rdata", 64'(rd), 64'h77);

    // Clear-on-read word 0 (only active when the feature is compiled in).
    @(negedge ACLK);
    hw_we[0]        = 1'b1;
    hw_wdata[31:0]  = 32'h5;
    @(negedge ACLK);
    hw_we = '0;
    axi_read(8'h00, rd, resp);
    check("t6_first_read", 64'(rd), 64'h5);
    axi_read(8'h00, rd, resp);
`ifdef AXIL_REG_BANK_COR_EN
    check("t6_second_read", 64'(rd), 64'h0);
`else
    check("t6_second_read", 64'(rd), 64'h5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_reg_bank.md
Name: axil_reg_bank

Overview:
- Parametrised AXI4-Lite slave register bank.
- Successor to the fixed 4 x 32-bit custom-memory IP; generalised in register count, data width and read-only/read-write mode per register.
- Adds byte strobes, decode/access error responses, hardware-update ports and per-register write pulses.
- Sits between the PS AXI interconnect and the systolic-array control/status logic.

Parameters:
- DATA_WIDTH, 32, bus and register width; 32 or 64 only.
- NUM_REGS, 16, number of registers, 1..256.
- ADDR_WIDTH, 8, AXI address width; must satisfy 2^ADDR_WIDTH >= NUM_REGS*DATA_WIDTH/8.
- RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only from the bus.
- COR_MASK, 0, NUM_REGS-bit mask; clear-on-read registers, used only with the optional feature.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- s_axi_awaddr  in  ADDR_WIDTH  write address.
- s_axi_awvalid / s_axi_awready  in/out  1  write address handshake.
- s_axi_wdata  in  DATA_WIDTH  write data.
- s_axi_wstrb  in  DATA_WIDTH/8  byte strobes.
- s_axi_wvalid / s_axi_wready  in/out  1  write data handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid / s_axi_bready  out/in  1  write response handshake.
- s_axi_araddr  in  ADDR_WIDTH  read address.
- s_axi_arvalid / s_axi_arready  in/out  1  read address handshake.
- s_axi_rdata  out  DATA_WIDTH  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid / s_axi_rready  out/in  1  read data handshake.
- reg_q  out  NUM_REGS*DATA_WIDTH  flattened register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- hw_we  in  NUM_REGS  hardware write enable per register.
- hw_wdata  in  NUM_REGS*DATA_WIDTH  hardware write data, same packing as reg_q.
- wr_pulse  out  NUM_REGS  one-cycle pulse after a successful bus write to register i.

Behaviour:
- Reset (ARESETN low, asynchronous):
  - All registers clear to 0.
  - awready, wready and arready are 0.
  - bvalid, rvalid, bresp, rresp, rdata and wr_pulse are 0.
  - Both FSMs go to IDLE.
  - Reset asserted mid-transaction aborts it; no response is issued.
- Word index = addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]. Low address bits are ignored.
- Write FSM states: W_IDLE, W_GOT_AW, W_GOT_W, W_RESP.
  - awready=1 in W_IDLE and W_GOT_W; wready=1 in W_IDLE and W_GOT_AW.
  - AW and W are accepted independently in either order, or in the same cycle.
  - On the edge where the second of the two is accepted, the write commits and the FSM moves to W_RESP. bvalid is 1 from the next cycle.
  - In W_RESP: awready=wready=0, bvalid holds until bready; then return to W_IDLE. Throughput is one write per 2 cycles minimum.
- Write commit rules:
  - index >= NUM_REGS: bresp=DECERR (2'b11), no update.
  - RO_MASK[index]=1: bresp=SLVERR (2'b10), no update.
  - Otherwise bresp=OKAY, and only the bytes with wstrb=1 update. wr_pulse[index]=1 for exactly the cycle after commit, even if wstrb=0.
- Read FSM states: R_IDLE, R_DATA.
  - arready=1 only in R_IDLE.
  - On the AR handshake, rdata/rresp are registered and the FSM moves to R_DATA; rvalid is 1 next cycle.
  - rvalid, rdata and rresp stay stable until rready, then return to R_IDLE.
  - Out-of-range read: rdata=0, rresp=DECERR. Reads of RO registers return OKAY.
- Simultaneous events:
  - hw_we[i] and a bus commit to register i in the same cycle: hw_wdata wins entirely, bresp is still OKAY, wr_pulse still fires.
  - A read handshake in the same cycle as a write commit to the same register returns the pre-write value.
  - Read and write FSMs are fully independent.
- reg_q reflects register state combinationally from the flops, with no extra latency.

Optional Feature:
- Macro: AXIL_REG_BANK_COR_EN.
- Defined: a read handshake to register i with COR_MASK[i]=1 clears register i at that edge; rdata carries the pre-clear value. If hw_we[i] is asserted in the same cycle, the hardware value wins and no clear happens.
- Undefined: COR_MASK is ignored; reads have no side effects.

Decomposition:
- Package axil_reg_bank_pkg holds:
  - resp_t constants RESP_OKAY, RESP_SLVERR and RESP_DECERR.
  - Write FSM enum wr_state_t and read FSM enum rd_state_t.
  - Function word_idx(addr).
- One sub-module, axil_reg_cell: a single DATA_WIDTH register with strobe merge, hw_we priority and optional clear. It is instantiated NUM_REGS times in a generate loop.

Test Plan:
- Reset then sequential writes of 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC, all wstrb=0xF, then reads -> each bresp/rresp=OKAY, rdata=1..4, wr_pulse[0..3] fire once each.
- Write 0xAABBCCDD to 0x0, then 0x11223344 with wstrb=0x5 -> read returns 0xAA22CC44.
- W presented 3 cycles before AW, bready held low 4 cycles -> single commit, bvalid stable 4 cycles, no second awready while bvalid=1.
- Write to index NUM_REGS (addr 0x40, defaults) -> bresp=DECERR, reg_q unchanged; read the same address -> rdata=0, rresp=DECERR.
- RO_MASK=0x2: bus write 0xFFFF to 0x4 -> SLVERR, value unchanged; then hw_we[1] with 0x1234 in the same cycle as a bus write to 0x4 -> read returns 0x1234.
- With AXIL_REG_BANK_COR_EN and COR_MASK=0x1: hw_we[0] loads 0x5, first read -> 0x5, second read -> 0x0.
